// File: rtl/conv3x3_sequencer.sv
// Frame-level controller for the 3x3 conv / 2x2 max-pool datapath: feeds pixels, tags valid outputs.
// Define SEQ_WEIGHT_LOAD_EN to load weights over wt_valid/wt_data instead of the w_in* pass-through.
module conv3x3_sequencer #(
    parameter int IMAGE_WIDTH  = 128,
    parameter int IMAGE_HEIGHT = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] cfg_width,
    input  logic [7:0] cfg_height,
    input  logic [1:0] cfg_op,
    input  logic       wt_valid,
    input  logic [7:0] wt_data,
    input  logic [7:0] w_in9,
    input  logic [7:0] w_in8,
    input  logic [7:0] w_in7,
    input  logic [7:0] w_in6,
    input  logic [7:0] w_in5,
    input  logic [7:0] w_in4,
    input  logic [7:0] w_in3,
    input  logic [7:0] w_in2,
    input  logic [7:0] w_in1,
    input  logic [7:0] bias_in,
    input  logic       in_valid,
    input  logic [7:0] in_pixel,
    output logic       in_ready,
    output logic [7:0] conv_pixel,
    output logic       pix_en,
    output logic [1:0] operation,
    output logic       paddingl,
    output logic       paddingr,
    output logic [7:0] w9,
    output logic [7:0] w8,
    output logic [7:0] w7,
    output logic [7:0] w6,
    output logic [7:0] w5,
    output logic [7:0] w4,
    output logic [7:0] w3,
    output logic [7:0] w2,
    output logic [7:0] w1,
    output logic [7:0] bias,
    output logic       out_valid,
    output logic [7:0] out_row,
    output logic [7:0] out_col,
    output logic       busy,
    output logic       done,
    output logic       err
);
    localparam logic [2:0] ST_IDLE   = 3'd0;
`ifdef SEQ_WEIGHT_LOAD_EN
    localparam logic [2:0] ST_LOAD   = 3'd1;
`endif
    localparam logic [2:0] ST_STREAM = 3'd2;
    localparam logic [2:0] ST_FLUSH  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [8:0] MAX_W = 9'(IMAGE_WIDTH);
    localparam logic [8:0] MAX_H = 9'(IMAGE_HEIGHT);

    logic [2:0] state;
    logic [7:0] width_q, height_q, row_q, col_q;
    logic       flush_sent;
    logic       s1_gen, s1_last, s1_pl, s1_pr;
    logic [7:0] s1_row, s1_col;
    logic       out_last;

    logic       cfg_bad, is_pool, push, last_push, flush_inj;
    logic       gen, g_last, g_pl, g_pr;
    logic [7:0] g_row, g_col;

    assign cfg_bad = (cfg_width < 8'd3) || (cfg_height < 8'd3)
                   || ({1'b0, cfg_width} > MAX_W) || ({1'b0, cfg_height} > MAX_H)
                   || ((cfg_op == 2'd1) && (cfg_width[0] || cfg_height[0]));
    assign is_pool   = (operation == 2'd1);
    assign in_ready  = (state == ST_STREAM);
    assign push      = in_valid && in_ready;
    assign last_push = push && (row_q == height_q - 8'd1) && (col_q == width_q - 8'd1);
    assign flush_inj = (state == ST_FLUSH) && !is_pool && !flush_sent;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

    // Conv outputs lag the push position by one pixel and one row (window centre);
    // the zero flush pixel stands in for position (H, 0).
    always_comb begin
        gen    = 1'b0;
        g_last = 1'b0;
        g_pl   = 1'b0;
        g_pr   = 1'b0;
        g_row  = 8'd0;
        g_col  = 8'd0;
        if (is_pool) begin
            if (push && row_q[0] && col_q[0]) begin
                gen    = 1'b1;
                g_row  = row_q >> 1;
                g_col  = col_q >> 1;
                g_last = last_push;
            end
        end else if (flush_inj) begin
            gen    = 1'b1;
            g_row  = height_q - 8'd2;
            g_col  = width_q - 8'd1;
            g_pr   = 1'b1;
            g_last = 1'b1;
        end else if (push && ((row_q >= 8'd3) || ((row_q == 8'd2) && (col_q != 8'd0)))) begin
            gen = 1'b1;
            if (col_q == 8'd0) begin
                g_row = row_q - 8'd2;
                g_col = width_q - 8'd1;
            end else begin
                g_row = row_q - 8'd1;
                g_col = col_q - 8'd1;
            end
            g_pl = (g_col == 8'd0);
            g_pr = (g_col == width_q - 8'd1);
        end
    end

`ifdef SEQ_WEIGHT_LOAD_EN
    logic [7:0] wreg [0:9];
    logic [3:0] wt_idx;
    logic       unused_w;

    assign unused_w = ^{w_in9, w_in8, w_in7, w_in6, w_in5, w_in4, w_in3, w_in2, w_in1, bias_in};
    assign w9 = wreg[0];
    assign w8 = wreg[1];
    assign w7 = wreg[2];
    assign w6 = wreg[3];
    assign w5 = wreg[4];
    assign w4 = wreg[5];
    assign w3 = wreg[6];
    assign w2 = wreg[7];
    assign w1 = wreg[8];
    assign bias = wreg[9];

    always_ff @(posedge clk) begin
        if (rst) begin
            wt_idx <= 4'd0;
            for (int i = 0; i < 10; i++) wreg[i] <= 8'd0;
        end else if (state == ST_IDLE) begin
            wt_idx <= 4'd0;
        end else if ((state == ST_LOAD) && wt_valid) begin
            wreg[wt_idx] <= wt_data;
            wt_idx       <= wt_idx + 4'd1;
        end
    end
`else
    logic unused_wt;

    assign unused_wt = ^{wt_valid, wt_data};
    assign w9 = w_in9;
    assign w8 = w_in8;
    assign w7 = w_in7;
    assign w6 = w_in6;
    assign w5 = w_in5;
    assign w4 = w_in4;
    assign w3 = w_in3;
    assign w2 = w_in2;
    assign w1 = w_in1;
    assign bias = bias_in;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            width_q    <= 8'd0;
            height_q   <= 8'd0;
            row_q      <= 8'd0;
            col_q      <= 8'd0;
            operation  <= 2'd0;
            flush_sent <= 1'b0;
            err        <= 1'b0;
            conv_pixel <= 8'd0;
            pix_en     <= 1'b0;
            s1_gen     <= 1'b0;
            s1_last    <= 1'b0;
            s1_pl      <= 1'b0;
            s1_pr      <= 1'b0;
            s1_row     <= 8'd0;
            s1_col     <= 8'd0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            paddingl   <= 1'b0;
            paddingr   <= 1'b0;
            out_row    <= 8'd0;
            out_col    <= 8'd0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (cfg_bad) begin
                            err <= 1'b1;
                        end else begin
                            width_q    <= cfg_width;
                            height_q   <= cfg_height;
                            operation  <= cfg_op;
                            row_q      <= 8'd0;
                            col_q      <= 8'd0;
                            flush_sent <= 1'b0;
`ifdef SEQ_WEIGHT_LOAD_EN
                            state <= ST_LOAD;
`else
                            state <= ST_STREAM;
`endif
                        end
                    end
                end
`ifdef SEQ_WEIGHT_LOAD_EN
                ST_LOAD: if (wt_valid && (wt_idx == 4'd9)) state <= ST_STREAM;
`endif
                ST_STREAM: if (last_push) state <= ST_FLUSH;
                ST_FLUSH: begin
                    if (flush_inj) flush_sent <= 1'b1;
                    if (out_valid && out_last) state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            if (push) begin
                if (col_q == width_q - 8'd1) begin
                    col_q <= 8'd0;
                    row_q <= row_q + 8'd1;
                end else begin
                    col_q <= col_q + 8'd1;
                end
            end

            pix_en <= push || flush_inj;
            if (push) conv_pixel <= in_pixel;
            else if (flush_inj) conv_pixel <= 8'd0;

            s1_gen    <= gen;
            s1_last   <= gen && g_last;
            s1_pl     <= g_pl;
            s1_pr     <= g_pr;
            s1_row    <= g_row;
            s1_col    <= g_col;
            out_valid <= s1_gen;
            out_last  <= s1_last;
            paddingl  <= s1_pl;
            paddingr  <= s1_pr;
            out_row   <= s1_row;
            out_col   <= s1_col;
        end
    end
endmodule

// File: tb/tb_conv3x3_sequencer.sv
// Directed bench for conv3x3_sequencer: frame runs scored against an expected-output queue.
module tb_conv3x3_sequencer;
    localparam int EW = 34;  // {due_cycle[15:0], row[7:0], col[7:0], pl, pr}

    logic       clk = 1'b0;
    logic       rst, start, wt_valid, in_valid;
    logic [7:0] cfg_width, cfg_height, wt_data, in_pixel;
    logic [1:0] cfg_op;
    logic [7:0] w_in9, w_in8, w_in7, w_in6, w_in5, w_in4, w_in3, w_in2, w_in1, bias_in;
    logic       in_ready, pix_en, paddingl, paddingr, out_valid, busy, done, err;
    logic [7:0] conv_pixel, out_row, out_col;
    logic [1:0] operation;
    logic [7:0] w9, w8, w7, w6, w5, w4, w3, w2, w1, bias;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int exp_done = -1;
    int done_seen = 0;
    logic [EW-1:0] exp_q[$];

    conv3x3_sequencer #(.IMAGE_WIDTH(128), .IMAGE_HEIGHT(128)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_op(cfg_op),
        .wt_valid(wt_valid), .wt_data(wt_data),
        .w_in9(w_in9), .w_in8(w_in8), .w_in7(w_in7), .w_in6(w_in6), .w_in5(w_in5),
        .w_in4(w_in4), .w_in3(w_in3), .w_in2(w_in2), .w_in1(w_in1), .bias_in(bias_in),
        .in_valid(in_valid), .in_pixel(in_pixel), .in_ready(in_ready),
        .conv_pixel(conv_pixel), .pix_en(pix_en), .operation(operation),
        .paddingl(paddingl), .paddingr(paddingr),
        .w9(w9), .w8(w8), .w7(w7), .w6(w6), .w5(w5), .w4(w4), .w3(w3), .w2(w2), .w1(w1),
        .bias(bias), .out_valid(out_valid), .out_row(out_row), .out_col(out_col),
        .busy(busy), .done(done), .err(err)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every clock, outputs sampled 1 time unit after the edge
    task automatic tick();
        logic [EW-1:0] e;
        @(posedge clk);
        #1;
        cycle++;
        if (out_valid) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_cycle", 32'(cycle), 32'(e[33:18]));
                check("out_row", 32'(out_row), 32'(e[17:10]));
                check("out_col", 32'(out_col), 32'(e[9:2]));
                check("paddingl", 32'(paddingl), 32'(e[1]));
                check("paddingr", 32'(paddingr), 32'(e[0]));
            end
        end
        if (done) begin
            done_seen++;
            check("done_cycle", 32'(cycle), 32'(exp_done));
        end
    endtask

    task automatic expect_out(input int due, input int row, input int col, input bit pl, input bit pr);
        exp_q.push_back({16'(due), 8'(row), 8'(col), pl, pr});
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
        check({tag, "_pix_en"}, 32'(pix_en), 0);
        check({tag, "_conv_pixel"}, 32'(conv_pixel), 0);
        check({tag, "_operation"}, 32'(operation), 0);
        check({tag, "_pads"}, 32'({paddingl, paddingr}), 0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_rc"}, 32'({out_row, out_col}), 0);
        check({tag, "_done_err"}, 32'({done, err}), 0);
        check({tag, "_weights"}, 32'({w9, w5, w1, bias}), 0);
    endtask

    // driver: start a frame and stream W*H pixels (value n+1); stop_at>=0 aborts after that push
    task automatic run_frame(input logic [1:0] op, input int wd, input int ht, input bit gap,
                             input int stop_at);
        int last;
        int d0;
        cfg_op = op;
        cfg_width = 8'(wd);
        cfg_height = 8'(ht);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", 32'(busy), 1);
        check("start_err", 32'(err), 0);
`ifdef SEQ_WEIGHT_LOAD_EN
        for (int k = 0; k < 10; k++) begin
            wt_valid = 1'b1;
            wt_data = 8'(9 - k);
            check("load_in_ready", 32'(in_ready), 0);
            tick();
        end
        wt_valid = 1'b0;
        check("load_w9", 32'(w9), 32'h09);
        check("load_w5", 32'(w5), 32'h05);
        check("load_w1", 32'(w1), 32'h01);
        check("load_bias", 32'(bias), 32'h00);
`endif
        check("stream_in_ready", 32'(in_ready), 1);
        check("operation", 32'(operation), 32'(op));
        for (int n = 0; n < wd * ht; n++) begin
            if (gap) begin
                in_valid = 1'b0;
                tick();
                check("gap_pix_en", 32'(pix_en), 0);
            end
            in_valid = 1'b1;
            in_pixel = 8'(n + 1);
            tick();
            in_valid = 1'b0;
            check("push_pix_en", 32'(pix_en), 1);
            check("push_pixel", 32'(conv_pixel), 32'(n + 1));
            if (op == 2'd0 && n >= 2 * wd + 1)
                expect_out(cycle + 1, (n - 1) / wd - 1, (n - 1) % wd,
                           ((n - 1) % wd) == 0, ((n - 1) % wd) == wd - 1);
            if (op == 2'd1 && ((n / wd) % 2 == 1) && ((n % wd) % 2 == 1))
                expect_out(cycle + 1, (n / wd) / 2, (n % wd) / 2, 1'b0, 1'b0);
            if (n == stop_at) return;
        end
        last = cycle;
        if (op == 2'd0) begin
            expect_out(last + 2, ht - 2, wd - 1, 1'b0, 1'b1);
            exp_done = last + 3;
        end else begin
            exp_done = last + 2;
        end
        d0 = done_seen;
        tick();
        check("flush_in_ready", 32'(in_ready), 0);
        check("flush_pix_en", 32'(pix_en), (op == 2'd0) ? 1 : 0);
        if (op == 2'd0) check("flush_pixel", 32'(conv_pixel), 0);
        for (int k = 0; k < 10 && done_seen == d0; k++) tick();
        check("done_count", 32'(done_seen - d0), 1);
        check("sb_drained", 32'(exp_q.size()), 0);
        exp_done = -1;
        tick();
        check("post_busy", 32'(busy), 0);
        check("post_done", 32'(done), 0);
    endtask

    task automatic reject(input string tag, input logic [1:0] op, input int wd, input int ht);
        cfg_op = op;
        cfg_width = 8'(wd);
        cfg_height = 8'(ht);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_err"}, 32'(err), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        tick();
        check({tag, "_err_pulse"}, 32'(err), 0);
        check({tag, "_idle"}, 32'(busy), 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        cfg_width = 8'd0;
        cfg_height = 8'd0;
        cfg_op = 2'd0;
        wt_valid = 1'b0;
        wt_data = 8'd0;
        in_valid = 1'b0;
        in_pixel = 8'd0;
        {w_in9, w_in8, w_in7, w_in6, w_in5, w_in4, w_in3, w_in2, w_in1, bias_in} = '0;

        tick();
        tick();
        check_idle_zero("reset");
        rst = 1'b0;
        tick();

`ifndef SEQ_WEIGHT_LOAD_EN
        w_in5 = 8'h55;
        #1;
        check("w5_pass", 32'(w5), 32'h55);
        w_in1 = 8'ha1;
        bias_in = 8'h3c;
        #1;
        check("w1_pass", 32'(w1), 32'ha1);
        check("bias_pass", 32'(bias), 32'h3c);
        {w_in5, w_in1, bias_in} = '0;
`endif

        reject("rej_w2", 2'd0, 2, 4);
        reject("rej_pool_w5", 2'd1, 5, 4);
        reject("rej_w200", 2'd0, 200, 4);

        run_frame(2'd0, 4, 4, 1'b0, -1);
        run_frame(2'd1, 4, 4, 1'b0, -1);
        run_frame(2'd0, 4, 4, 1'b1, -1);

        // reset after push n=6 of a conv frame: nothing in flight may surface
        run_frame(2'd0, 4, 4, 1'b0, 6);
        rst = 1'b1;
        tick();
        check_idle_zero("midrst");
        rst = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        check("midrst_no_done", 32'(done_seen), 3);
        check("midrst_quiet", 32'({busy, out_valid}), 0);

        run_frame(2'd0, 5, 4, 1'b0, -1);
        check("total_done", 32'(done_seen), 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv3x3_sequencer.md
# conv3x3_sequencer

Frame-level controller for the 3x3 convolution/max-pool datapath. It accepts a configured frame and a pixel stream, then drives the datapath's pixel input, collector shift enable, operation select, left/right padding flags and weight/bias bus. It flags every cycle in which the datapath's combinational result is a valid output pixel, and tags that cycle with its output coordinates. It sits between the frame DMA/line source and the convolution unit, and is the only block that writes the datapath's control inputs.

## Interface
Parameters:
- IMAGE_WIDTH, 128, maximum accepted frame width in pixels
- IMAGE_HEIGHT, 128, maximum accepted frame height in pixels

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin frame; sampled only in IDLE
- cfg_width  in  8  frame width, latched on accepted start
- cfg_height  in  8  frame height, latched on accepted start
- cfg_op  in  2  0 = conv3x3, 1 = maxpool2x2; latched on accepted start
- wt_valid  in  1  weight byte strobe (macro build only)
- wt_data  in  8  weight byte (macro build only)
- w_in9..w_in1, bias_in  in  8 each  direct weights (non-macro build only)
- in_valid  in  1  input pixel valid
- in_pixel  in  8  input pixel
- in_ready  out  1  sequencer accepts a pixel this cycle
- conv_pixel  out  8  registered pixel to datapath
- pix_en  out  1  registered collector shift enable
- operation  out  2  latched cfg_op
- paddingl, paddingr  out  1 each  column padding flags, aligned with out_valid
- w9..w1, bias  out  8 each  weights to datapath
- out_valid  out  1  datapath result is a valid output pixel this cycle
- out_row, out_col  out  8 each  output coordinates
- busy  out  1  not in IDLE
- done  out  1  one-cycle pulse at end of frame
- err  out  1  one-cycle pulse on rejected start

## Operation
- States: IDLE, LOAD (macro build only), STREAM, FLUSH, DONE.
- IDLE, start=1:
  - Rejected if cfg_width<3, cfg_height<3, cfg_width>IMAGE_WIDTH or cfg_height>IMAGE_HEIGHT.
  - Also rejected for maxpool when width or height is odd.
  - Rejection: err pulses and the block stays in IDLE.
  - Otherwise: latch the configuration, then go to LOAD (macro build) or STREAM.
- LOAD: accept 10 wt_valid bytes in the order w9, w8, …, w1, bias, then go to STREAM.
- STREAM:
  - in_ready=1. A push is in_valid&in_ready.
  - A linear index n (0…W·H−1) increments per push.
  - Gaps in in_valid insert no pix_en.
- Conv, push index n≥2W+1 generates an output:
  - center row = (n−1)/W − 1, center col = (n−1) mod W.
  - paddingl = (col==0); paddingr = (col==W−1).
  - After push W·H−1, go to FLUSH.
  - FLUSH: in_ready=0; inject one zero pixel (pix_en=1) as index W·H, which produces the final output (row H−2, col W−1).
  - Total outputs: (H−2)·W.
- Maxpool, a push at an odd row r and odd column c generates an output:
  - Output at (r/2, c/2), paddingl=paddingr=0.
  - No flush. Total outputs: (H/2)·(W/2).
- DONE: done=1 for one cycle, then IDLE.
- start outside IDLE is ignored.
- Counters are 8-bit with no wrap within a legal frame. The row counter resets per frame.

## Timing
- Push in cycle t: conv_pixel/pix_en valid in t+1; out_valid, paddingl, paddingr, out_row and out_col valid in t+2.
- Latency from push to output is exactly 2 cycles, independent of gaps.
- There is no output backpressure; consumers sample pixel_out when out_valid=1.
- done asserts the cycle after the last out_valid.
- Reset values: all outputs 0, state IDLE, counters 0, weight registers 0.
- Reset mid-frame: next cycle all outputs 0 and state IDLE; pixels in flight are dropped, with no out_valid or done.
- Simultaneous wt_valid and the 10th byte: the transition to STREAM takes effect next cycle, and in_ready=0 during the loading cycle.

## Configuration
- SEQ_WEIGHT_LOAD_EN defined:
  - Internal 10-byte weight register file, loaded in LOAD, drives w9..bias.
  - w_in*/bias_in are unused.
  - Weights persist across frames until the next load.
- SEQ_WEIGHT_LOAD_EN undefined:
  - No LOAD state; wt_valid/wt_data are ignored.
  - w9..bias are combinational pass-throughs of w_in9..bias_in.

## Test plan
- Conv, 4x4, pixels 1..16 contiguous, weights all 1, bias 0 -> 8 out_valid.
  - First out_valid 2 cycles after push n=9, at (1,0) with paddingl=1.
  - Last out_valid after FLUSH, at (2,3) with paddingr=1.
  - done pulses the next cycle.
- Maxpool, 4x4 -> 4 out_valid, 2 cycles after pushes n=5,7,13,15, at (0,0), (0,1), (1,0), (1,1); padding flags 0.
- Conv 4x4 with in_valid low on alternate cycles -> pix_en pulses only on pushes; same 8 outputs and coordinates as the first scenario.
- Macro build: load bytes 9,8,…,1,0 then start -> w9=9, w1=1, bias=0 held through STREAM. Non-macro build: w_in5=0x55 -> w5=0x55 in the same cycle.
- Reset asserted after push n=6 -> next cycle busy=0 and all outputs 0, with no done. A new start then runs a clean frame.
- start with cfg_width=2, or maxpool with cfg_width=5 -> err=1 for one cycle, busy remains 0.
